instr_sequencer: RTL and testbench

//  Multi-cycle control FSM for the 32-bit IR/GPR datapath: fetches from instruction memory, latches IR, decodes.

---
 rtl/instr_sequencer_if.sv | 53 +++++
 rtl/instr_sequencer.sv | 170 +++++++++++++++++
 tb/tb_instr_sequencer.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_sequencer_if.sv
// ============================================================================
// Module      : instr_sequencer_if
// Description : Bundle between the instruction sequencer, instruction memory
//               and the IR/GPR/ALU datapath.
//               master : sequencer side (drives fetch request, IR, decoded
//                        fields, GPR write strobe, PC and status)
//               slave  : environment side (drives start, imem_rdata, imem_ack)
//               Signals:
//                 start                       run request (level)
//                 imem_req/imem_addr          fetch request / address
//                 imem_rdata/imem_ack         fetched word / acknowledge
//                 ir, alu_op, imm_sel         instruction register, decode
//                 rs1_addr/rs2_addr/rd_addr   GPR addresses
//                 gpr_we                      GPR write strobe
//                 pc, busy, halted, illegal   PC and status
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface instr_sequencer_if #(
  parameter int PC_W = 8
);
  logic            start;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            imem_ack;
  logic [31:0]     ir;
  logic [4:0]      alu_op;
  logic            imm_sel;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [4:0]      rd_addr;
  logic            gpr_we;
  logic [PC_W-1:0] pc;
  logic            busy;
  logic            halted;
  logic            illegal;

  modport master (
    input  start, imem_rdata, imem_ack,
    output imem_req, imem_addr, ir, alu_op, imm_sel,
           rs1_addr, rs2_addr, rd_addr, gpr_we, pc, busy, halted, illegal
  );

  modport slave (
    output start, imem_rdata, imem_ack,
    input  imem_req, imem_addr, ir, alu_op, imm_sel,
           rs1_addr, rs2_addr, rd_addr, gpr_we, pc, busy, halted, illegal
  );
endinterface

`default_nettype wire

// File: rtl/instr_sequencer.sv
// ============================================================================
// Module      : instr_sequencer
// Description : Multi-cycle, non-pipelined control FSM for the 32-bit IR/GPR
//               datapath. Fetches an instruction word, latches it into IR,
//               decodes it, sequences execute (MUL_LAT cycles for MUL, one
//               cycle otherwise) and a one-cycle GPR write-back. Owns PC.
//               Ports:
//                 clk        clock, all logic on posedge
//                 sys_rst_n  synchronous active-low reset
//                 bus        instr_sequencer_if.master (fetch handshake,
//                            IR/decode outputs, gpr_we, pc, status)
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_sequencer #(
  parameter int PC_W     = 8,
  parameter int RESET_PC = 0,
  parameter int MUL_LAT  = 3
) (
  input  wire logic         clk,
  input  wire logic         sys_rst_n,
  instr_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [PC_W-1:0] c_reset_pc = PC_W'(RESET_PC);
  // Counter is loaded with latency-1 so EXEC lasts exactly MUL_LAT cycles.
  localparam logic [3:0]      c_mul_cnt  = 4'(MUL_LAT - 1);
  localparam logic [4:0]      c_op_nop   = 5'd0;
  localparam logic [4:0]      c_op_mul   = 5'd4;
  localparam logic [4:0]      c_op_halt  = 5'd31;

  state_t          r_state;
  logic [3:0]      r_exec_cnt;
  logic            r_imem_req;
  logic [31:0]     r_ir;
  logic [4:0]      r_alu_op;
  logic            r_imm_sel;
  logic [4:0]      r_rs1_addr;
  logic [4:0]      r_rs2_addr;
  logic [4:0]      r_rd_addr;
  logic            r_gpr_we;
  logic [PC_W-1:0] r_pc;
  logic            r_busy;
  logic            r_halted;
  logic            r_illegal;

  // Decision in DECODE is taken straight from IR (just loaded in FETCH).
  logic [4:0] w_op;
  logic       w_op_illegal;
  assign w_op         = r_ir[31:27];
  assign w_op_illegal = (w_op > 5'd11) && (w_op != c_op_halt);

  always_ff @(posedge clk) begin
    if (!sys_rst_n) begin
      r_state    <= S_IDLE;
      r_exec_cnt <= 4'd0;
      r_imem_req <= 1'b0;
      r_ir       <= 32'd0;
      r_alu_op   <= 5'd0;
      r_imm_sel  <= 1'b0;
      r_rs1_addr <= 5'd0;
      r_rs2_addr <= 5'd0;
      r_rd_addr  <= 5'd0;
      r_gpr_we   <= 1'b0;
      r_pc       <= c_reset_pc;
      r_busy     <= 1'b0;
      r_halted   <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state    <= S_FETCH;
            r_imem_req <= 1'b1;
            r_busy     <= 1'b1;
          end
        end

        S_FETCH: begin
          // Request stays up until the memory answers; no timeout.
          if (bus.imem_ack) begin
            r_ir       <= bus.imem_rdata;
            r_imem_req <= 1'b0;
            r_state    <= S_DECODE;
          end
        end

        S_DECODE: begin
          r_alu_op   <= r_ir[31:27];
          r_imm_sel  <= r_ir[16];
          r_rs1_addr <= r_ir[21:17];
          r_rs2_addr <= r_ir[15:11];
          r_rd_addr  <= r_ir[26:22];
          if (w_op_illegal || (w_op == c_op_halt)) begin
            // PC is left pointing at the offending / halting instruction.
            r_state   <= S_HALT;
            r_halted  <= 1'b1;
            r_busy    <= 1'b0;
            r_illegal <= w_op_illegal;
          end else if (w_op == c_op_nop) begin
            r_pc       <= r_pc + PC_W'(1);
            r_state    <= S_FETCH;
            r_imem_req <= 1'b1;
          end else begin
            r_exec_cnt <= (w_op == c_op_mul) ? c_mul_cnt : 4'd0;
            r_state    <= S_EXEC;
          end
        end

        S_EXEC: begin
          if (r_exec_cnt == 4'd0) begin
            r_state  <= S_WB;
            r_gpr_we <= 1'b1;
          end else begin
            r_exec_cnt <= r_exec_cnt - 4'd1;
          end
        end

        S_WB: begin
          r_gpr_we   <= 1'b0;
          r_pc       <= r_pc + PC_W'(1);  // wraps silently
          r_state    <= S_FETCH;
          r_imem_req <= 1'b1;
        end

        S_HALT: begin
          if (bus.start) begin
            r_pc       <= c_reset_pc;
            r_illegal  <= 1'b0;
            r_halted   <= 1'b0;
            r_busy     <= 1'b1;
            r_imem_req <= 1'b1;
            r_state    <= S_FETCH;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.imem_req  = r_imem_req;
  assign bus.imem_addr = r_pc;
  assign bus.ir        = r_ir;
  assign bus.alu_op    = r_alu_op;
  assign bus.imm_sel   = r_imm_sel;
  assign bus.rs1_addr  = r_rs1_addr;
  assign bus.rs2_addr  = r_rs2_addr;
  assign bus.rd_addr   = r_rd_addr;
  assign bus.gpr_we    = r_gpr_we;
  assign bus.pc        = r_pc;
  assign bus.busy      = r_busy;
  assign bus.halted    = r_halted;
  assign bus.illegal   = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_instr_sequencer.sv
// ============================================================================
// Module      : tb_instr_sequencer
// Description : Self-checking bench for instr_sequencer. An instruction
//               memory responder with per-fetch programmable ack delay
//               serves a program image; a monitor records fetches, strobes
//               and busy cycles; a program-level reference model predicts
//               write-backs, final PC, illegal flag and cycle counts.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_sequencer;
  localparam int PC_W    = 8;
  localparam int MUL_LAT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_sequencer_if #(.PC_W(PC_W)) bus();

  instr_sequencer #(.PC_W(PC_W), .RESET_PC(0), .MUL_LAT(MUL_LAT)) dut (
    .clk       (clk),
    .sys_rst_n (rst_n),
    .bus       (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [256];
  int dly[$];
  int fidx;

  // ---------------- instruction memory responder ----------------
  bit rsp_in, rsp_done;
  int rsp_wait, rsp_d;
  always @(negedge clk) begin
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = $urandom;
    if (!bus.imem_req) begin
      rsp_in = 0; rsp_done = 0;
    end else if (!rsp_done) begin
      if (!rsp_in) begin
        rsp_in = 1; rsp_wait = 0;
        rsp_d = (fidx < dly.size()) ? dly[fidx] : 0;
        fidx++;
      end
      if (rsp_wait == rsp_d) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = mem[bus.imem_addr];
        rsp_done = 1;
      end else begin
        rsp_wait++;
      end
    end
  end

  // ---------------- monitor ----------------
  int cyc = 0, busy_cnt, we_cnt, we_rise, req_run;
  bit prev_req, prev_we;
  int fetch_addr_q[$], fetch_cyc_q[$], req_len_q[$];
  int wr_rd_q[$], wr_cyc_q[$], wr_pc_q[$], wr_op_q[$];
  logic [31:0] wr_ir_q[$];

  always @(posedge clk) begin
    #1;
    cyc++;
    if (bus.busy === 1'b1) busy_cnt++;
    if (bus.imem_req === 1'b1) begin
      if (!prev_req) begin
        fetch_addr_q.push_back(int'(bus.imem_addr));
        fetch_cyc_q.push_back(cyc);
      end
      req_run++;
    end else if (prev_req) begin
      req_len_q.push_back(req_run);
      req_run = 0;
    end
    if (bus.gpr_we === 1'b1) begin
      we_cnt++;
      if (!prev_we) we_rise++;
      wr_rd_q.push_back(int'(bus.rd_addr));
      wr_cyc_q.push_back(cyc);
      wr_pc_q.push_back(int'(bus.pc));
      wr_op_q.push_back(int'(bus.alu_op));
      wr_ir_q.push_back(bus.ir);
    end
    prev_req = (bus.imem_req === 1'b1);
    prev_we  = (bus.gpr_we === 1'b1);
  end

  task automatic clear_mon();
    busy_cnt = 0; we_cnt = 0; we_rise = 0; req_run = 0;
    fetch_addr_q.delete(); fetch_cyc_q.delete(); req_len_q.delete();
    wr_rd_q.delete(); wr_cyc_q.delete(); wr_pc_q.delete();
    wr_op_q.delete(); wr_ir_q.delete();
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic imm,
                                     input logic [15:0] low);
    return {op, rd, rs1, imm, low};
  endfunction

  // ---------------- program-level reference model ----------------
  int m_rd_q[$], m_op_q[$];
  int m_pc, m_busy, m_nfetch;
  bit m_ill;

  task automatic model_run();
    int pc = 0;
    int k  = 0;
    m_rd_q.delete(); m_op_q.delete();
    m_busy = 0; m_nfetch = 0; m_ill = 0;
    for (int step = 0; step < 600; step++) begin
      logic [31:0] w;
      int op, d;
      w  = mem[pc];
      op = int'(w[31:27]);
      d  = (k < dly.size()) ? dly[k] : 0;
      k++;
      m_nfetch++;
      m_busy += d + 2;                        // fetch wait + decode
      if (op == 31) break;
      if (op >= 12) begin m_ill = 1; break; end
      if (op != 0) begin
        m_busy += ((op == 4) ? MUL_LAT : 1) + 1;  // execute + write-back
        m_rd_q.push_back(int'(w[26:22]));
        m_op_q.push_back(op);
      end
      pc = (pc + 1) % 256;
    end
    m_pc = pc;
  endtask

  task automatic run_prog(input int budget, output bit ok);
    clear_mon();
    fidx = 0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (bus.halted === 1'b1) begin ok = 1; break; end
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({bus.imem_req, bus.gpr_we, bus.busy, bus.halted, bus.illegal} !== 5'd0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b exp 00000",
        {bus.imem_req, bus.gpr_we, bus.busy, bus.halted, bus.illegal});
    end
    n_tests++;
    if ({bus.ir, bus.alu_op, bus.imm_sel, bus.rs1_addr, bus.rs2_addr, bus.rd_addr} !== 58'd0) begin
      n_fail++; $display("FAIL reset_ir: got ir=%h alu_op=%0d exp 0", bus.ir, bus.alu_op);
    end
    n_tests++;
    if (bus.pc !== 8'd0 || bus.imem_addr !== 8'd0) begin
      n_fail++; $display("FAIL reset_pc: got %0d/%0d exp 0", bus.pc, bus.imem_addr);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b0 || bus.imem_req !== 1'b0) begin
      n_fail++; $display("FAIL idle_hold: got busy=%b req=%b exp 0 0", bus.busy, bus.imem_req);
    end
  endtask

  task automatic test_add_delayed();
    bit ok;
    logic [31:0] add_w;
    add_w  = mk(5'd2, 5'd0, 5'd2, 1'b1, 16'd4);
    mem[0] = add_w;
    mem[1] = mk(5'd31, 5'd0, 5'd0, 1'b0, 16'd0);
    dly = '{3, 0};
    model_run();
    run_prog(100, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL add_halt_timeout: halted=%b exp 1", bus.halted); end
    n_tests++;
    if (req_len_q.size() < 1 || req_len_q[0] != 4) begin
      n_fail++; $display("FAIL add_req_len: got %0d exp 4", req_len_q.size() ? req_len_q[0] : -1);
    end
    n_tests++;
    if (we_cnt != 1 || we_rise != 1) begin
      n_fail++; $display("FAIL add_we_count: got %0d cycles/%0d pulses exp 1/1", we_cnt, we_rise);
    end
    n_tests++;
    if (wr_rd_q.size() != 1 || wr_rd_q[0] != 0 || wr_ir_q[0] !== add_w || wr_op_q[0] != 2 || wr_pc_q[0] != 0) begin
      n_fail++; $display("FAIL add_wb_fields: got n=%0d rd=%0d ir=%h exp rd=0 ir=%h",
        wr_rd_q.size(), wr_rd_q.size() ? wr_rd_q[0] : -1, wr_ir_q.size() ? wr_ir_q[0] : 32'hx, add_w);
    end
    n_tests++;
    if (int'(bus.pc) != m_pc || busy_cnt != m_busy) begin
      n_fail++; $display("FAIL add_pc_busy: got pc=%0d busy=%0d exp pc=%0d busy=%0d", bus.pc, busy_cnt, m_pc, m_busy);
    end
  endtask

  task automatic test_mul_latency();
    bit ok;
    mem[0] = mk(5'd4, 5'd7, 5'd1, 1'b0, 16'h1000);
    mem[1] = mk(5'd31, 5'd0, 5'd0, 1'b0, 16'd0);
    dly = '{0, 0};
    model_run();
    run_prog(100, ok);
    n_tests++;
    if (!ok || we_cnt != 1) begin
      n_fail++; $display("FAIL mul_we_count: got ok=%b we=%0d exp 1 1", ok, we_cnt);
    end
    n_tests++;
    if (wr_cyc_q.size() < 1 || fetch_cyc_q.size() < 1 ||
        wr_cyc_q[0] - fetch_cyc_q[0] + 1 != 3 + MUL_LAT) begin
      n_fail++; $display("FAIL mul_latency: got %0d exp %0d",
        (wr_cyc_q.size() && fetch_cyc_q.size()) ? wr_cyc_q[0] - fetch_cyc_q[0] + 1 : -1, 3 + MUL_LAT);
    end
    n_tests++;
    if (busy_cnt != m_busy || (wr_rd_q.size() && wr_rd_q[0] != 7)) begin
      n_fail++; $display("FAIL mul_busy: got busy=%0d exp %0d", busy_cnt, m_busy);
    end
  endtask

  task automatic test_illegal();
    bit ok;
    for (int i = 0; i < 5; i++) mem[i] = {5'd0, 27'($urandom)};
    mem[5] = {5'd12, 27'($urandom)};
    dly.delete();
    for (int i = 0; i < 6; i++) dly.push_back($urandom_range(0, 3));
    model_run();
    run_prog(200, ok);
    n_tests++;
    if (!ok || bus.illegal !== 1'b1 || m_ill != 1) begin
      n_fail++; $display("FAIL ill_flag: got halted=%b illegal=%b exp 1 1", bus.halted, bus.illegal);
    end
    n_tests++;
    if (bus.pc !== 8'd5 || we_cnt != 0 || busy_cnt != m_busy) begin
      n_fail++; $display("FAIL ill_state: got pc=%0d we=%0d busy=%0d exp 5 0 %0d", bus.pc, we_cnt, busy_cnt, m_busy);
    end
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n_tests++;
    if (bus.illegal !== 1'b0 || bus.halted !== 1'b0 || bus.pc !== 8'd0 || bus.imem_req !== 1'b1) begin
      n_fail++; $display("FAIL ill_restart: got ill=%b halt=%b pc=%0d req=%b exp 0 0 0 1",
        bus.illegal, bus.halted, bus.pc, bus.imem_req);
    end
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.halted === 1'b1) begin ok = 1; break; end
    end
    n_tests++;
    if (!ok || bus.illegal !== 1'b1 || bus.pc !== 8'd5) begin
      n_fail++; $display("FAIL ill_rerun: got ok=%b ill=%b pc=%0d exp 1 1 5", ok, bus.illegal, bus.pc);
    end
  endtask

  task automatic test_nop_wrap();
    int bad_addr, bad_gap;
    for (int i = 0; i < 256; i++) mem[i] = {5'd0, 27'($urandom)};
    dly.delete();
    do_reset();
    clear_mon();
    fidx = 0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2 * 260) @(negedge clk);
    bad_addr = 0; bad_gap = 0;
    n_tests++;
    if (fetch_addr_q.size() < 258) begin
      n_fail++; $display("FAIL nop_fetches: got %0d exp >=258", fetch_addr_q.size());
    end else begin
      for (int i = 0; i < 258; i++) if (fetch_addr_q[i] != i % 256) bad_addr++;
      for (int i = 0; i < 257; i++) if (fetch_cyc_q[i + 1] - fetch_cyc_q[i] != 2) bad_gap++;
    end
    n_tests++;
    if (bad_addr != 0 || (fetch_addr_q.size() >= 258 && fetch_addr_q[256] != 0)) begin
      n_fail++; $display("FAIL nop_wrap_addr: got %0d bad addresses exp 0", bad_addr);
    end
    n_tests++;
    if (bad_gap != 0) begin
      n_fail++; $display("FAIL nop_cycles: got %0d bad gaps exp 0", bad_gap);
    end
    n_tests++;
    if (we_cnt != 0) begin
      n_fail++; $display("FAIL nop_no_we: got %0d exp 0", we_cnt);
    end
    do_reset();
  endtask

  task automatic test_reset_mid_exec();
    bit ok;
    mem[0] = mk(5'd4, 5'd9, 5'd3, 1'b0, 16'd0);
    mem[1] = mk(5'd31, 5'd0, 5'd0, 1'b0, 16'd0);
    dly.delete();
    clear_mon();
    fidx = 0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (bus.alu_op !== 5'd4 || bus.busy !== 1'b1 || bus.gpr_we !== 1'b0) begin
      n_fail++; $display("FAIL rst_pre_exec: got op=%0d busy=%b we=%b exp 4 1 0", bus.alu_op, bus.busy, bus.gpr_we);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({bus.imem_req, bus.gpr_we, bus.busy, bus.halted, bus.illegal, bus.ir, bus.alu_op, bus.rd_addr} !== 47'd0
        || bus.pc !== 8'd0 || we_cnt != 0) begin
      n_fail++; $display("FAIL rst_mid_exec: got busy=%b ir=%h pc=%0d we=%0d exp all 0",
        bus.busy, bus.ir, bus.pc, we_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // start pulsed again while busy must not disturb the run
    mem[0] = mk(5'd2, 5'd1, 5'd2, 1'b0, 16'h1800);
    mem[1] = mk(5'd3, 5'd2, 5'd1, 1'b1, 16'd7);
    mem[2] = mk(5'd31, 5'd0, 5'd0, 1'b0, 16'd0);
    dly = '{$urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3)};
    model_run();
    clear_mon();
    fidx = 0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.halted === 1'b1) begin ok = 1; break; end
      @(negedge clk);
    end
    n_tests++;
    if (!ok || busy_cnt + 0 != m_busy || int'(bus.pc) != m_pc) begin
      n_fail++; $display("FAIL busy_start: got ok=%b busy=%0d pc=%0d exp 1 %0d %0d", ok, busy_cnt, bus.pc, m_busy, m_pc);
    end
    n_tests++;
    if (wr_rd_q.size() != 2 || wr_rd_q[0] != 1 || wr_rd_q[1] != 2) begin
      n_fail++; $display("FAIL busy_start_wb: got %0d writes exp 2 (rd 1,2)", wr_rd_q.size());
    end
  endtask

  task automatic test_program();
    bit ok;
    mem[0] = mk(5'd1, 5'd4, 5'd0, 1'b1, 16'd55);
    mem[1] = mk(5'd2, 5'd0, 5'd4, 1'b0, {5'd5, 11'd0});
    mem[2] = mk(5'd31, 5'd0, 5'd0, 1'b0, 16'd0);
    dly = '{1, 0, 2};
    run_prog(100, ok);
    n_tests++;
    if (!ok || we_rise != 2 || we_cnt != 2) begin
      n_fail++; $display("FAIL prog_pulses: got ok=%b pulses=%0d exp 1 2", ok, we_rise);
    end
    n_tests++;
    if (wr_rd_q.size() != 2 || wr_rd_q[0] != 4 || wr_rd_q[1] != 0) begin
      n_fail++; $display("FAIL prog_rd: got n=%0d first=%0d exp rd 4 then 0",
        wr_rd_q.size(), wr_rd_q.size() ? wr_rd_q[0] : -1);
    end
    n_tests++;
    if (bus.halted !== 1'b1 || bus.pc !== 8'd2 || bus.illegal !== 1'b0) begin
      n_fail++; $display("FAIL prog_halt: got halted=%b pc=%0d exp 1 2", bus.halted, bus.pc);
    end
  endtask

  task automatic test_random();
    bit ok;
    for (int it = 0; it < 8; it++) begin
      int len, r;
      len = $urandom_range(3, 10);
      dly.delete();
      for (int i = 0; i < len; i++) begin
        int op;
        r = $urandom_range(0, 15);
        if (r < 12)       op = r;
        else if (r == 15) op = $urandom_range(12, 30);
        else              op = $urandom_range(0, 11);
        mem[i] = {5'(op), 27'($urandom)};
      end
      mem[len] = {5'd31, 27'($urandom)};
      for (int i = 0; i <= len; i++) dly.push_back($urandom_range(0, 3));
      model_run();
      run_prog(400, ok);
      n_tests++;
      if (!ok || bus.illegal !== m_ill || int'(bus.pc) != m_pc) begin
        n_fail++; $display("FAIL rnd%0d_end: got ok=%b ill=%b pc=%0d exp 1 %0d %0d", it, ok, bus.illegal, bus.pc, m_ill, m_pc);
      end
      n_tests++;
      if (busy_cnt != m_busy || fetch_addr_q.size() != m_nfetch) begin
        n_fail++; $display("FAIL rnd%0d_cycles: got busy=%0d fetches=%0d exp %0d %0d",
          it, busy_cnt, fetch_addr_q.size(), m_busy, m_nfetch);
      end
      n_tests++;
      if (wr_rd_q.size() != m_rd_q.size() || we_rise != m_rd_q.size()) begin
        n_fail++; $display("FAIL rnd%0d_nwb: got %0d exp %0d", it, wr_rd_q.size(), m_rd_q.size());
      end else begin
        for (int i = 0; i < m_rd_q.size(); i++) begin
          n_tests++;
          if (wr_rd_q[i] != m_rd_q[i] || wr_op_q[i] != m_op_q[i]) begin
            n_fail++; $display("FAIL rnd%0d_wb%0d: got rd=%0d op=%0d exp rd=%0d op=%0d",
              it, i, wr_rd_q[i], wr_op_q[i], m_rd_q[i], m_op_q[i]);
          end
        end
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    test_reset();
    test_add_delayed();
    test_mul_latency();
    test_illegal();
    test_nop_wrap();
    test_reset_mid_exec();
    test_program();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
